// File: rtl/mrf_pkg.sv
// Shared types and helpers for the multiport register file.
package mrf_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of entries for a given address width.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Low bit index of port 'port' inside a packed bus of 'w'-bit lanes.
    function automatic int unsigned lsb_of(input int unsigned port, input int unsigned w);
        return port * w;
    endfunction

endpackage

// File: rtl/mrf_scoreboard.sv
// Pending-write scoreboard: issue sets a bit, writeback clears it, set wins.
module mrf_scoreboard
    import mrf_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run,
    input  logic                             iss_en,
    input  logic [ADDR_W-1:0]                iss_addr,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    output logic [depth_of(ADDR_W)-1:0]      pending
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);
    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] pending_next;

    // Next pending vector: clear first, then set so a new producer wins.
    always_comb begin
        set_vec      = '0;
        clr_vec      = '0;
        if (run && iss_en) begin
            set_vec = ONE << iss_addr;
        end
        if (run && wr_en) begin
            clr_vec = ONE << wr_addr;
        end
        pending_next = (pending & ~clr_vec) | set_vec;
        if (ZERO_REG != 0) begin
            pending_next[0] = 1'b0;
        end
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Multiport register file with init sweep, hazard scoreboard and registered reads.
// Optional macro REGFILE_BYPASS_EN: same-cycle read of the written entry returns
// the new data (write-first); otherwise reads return the old value (read-first).
module multiport_reg_file
    import mrf_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             ready,
    input  logic [NUM_RD-1:0]                rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]         rd_addr,
    output logic [NUM_RD*DATA_W-1:0]         rd_data,
    output logic [NUM_RD-1:0]                rd_valid,
    output logic [NUM_RD-1:0]                rd_hazard,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             iss_en,
    input  logic [ADDR_W-1:0]                iss_addr,
    output logic [depth_of(ADDR_W)-1:0]      pending
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clear_ptr;

    logic              run_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] rd_addr_c [NUM_RD];
    logic [DATA_W-1:0] rd_word_c [NUM_RD];
    logic              rd_haz_c  [NUM_RD];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: sweep every entry once, then run until reset.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clear_ptr == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Outputs: storage write port is the sweep in INIT, writeback in RUN.
    always_comb begin
        run_c       = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = clear_ptr;
        mem_wdata_c = '0;
        case (state)
            INIT: begin
                mem_we_c = 1'b1;
            end
            RUN: begin
                run_c       = 1'b1;
                mem_we_c    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
                mem_waddr_c = wr_addr;
                mem_wdata_c = wr_data;
            end
            default: ;
        endcase
    end

    // Sweep pointer advances only while initialising.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clear_ptr <= '0;
        end else if (state == INIT) begin
            clear_ptr <= clear_ptr + ADDR_W'(1);
        end
    end

    // Ready follows RUN by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready <= 1'b0;
        end else begin
            ready <= run_c;
        end
    end

    // Storage array; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    mrf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run_c),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .pending  (pending)
    );

    // Per-port read value and hazard, including zero-register and bypass handling.
    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_addr_c[i] = rd_addr[lsb_of(i, ADDR_W) +: ADDR_W];
            rd_word_c[i] = mem[rd_addr_c[i]];
            rd_haz_c[i]  = pending[rd_addr_c[i]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_c[i])) begin
                rd_word_c[i] = wr_data;
                rd_haz_c[i]  = iss_en && (iss_addr == rd_addr_c[i]);
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr_c[i] == '0)) begin
                rd_word_c[i] = '0;
                rd_haz_c[i]  = 1'b0;
            end
        end
    end

    // Registered read ports; data holds when a port is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= '0;
            rd_hazard <= '0;
            rd_data   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (run_c && rd_en[i]) begin
                    rd_valid[i]                           <= 1'b1;
                    rd_hazard[i]                          <= rd_haz_c[i];
                    rd_data[lsb_of(i, DATA_W) +: DATA_W] <= rd_word_c[i];
                end else begin
                    rd_valid[i]  <= 1'b0;
                    rd_hazard[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed self-checking bench for multiport_reg_file (default parameters).
module tb_multiport_reg_file;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned DEPTH  = 32;

    logic                     clk;
    logic                     rst_n;
    logic                     ready;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD-1:0]        rd_hazard;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [DEPTH-1:0]         pending;

    int n_checks = 0;
    int n_fail   = 0;

    multiport_reg_file #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_hazard (rd_hazard),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; wr_en = 1'b0; iss_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++;
        if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", rd_valid); end
        n_checks++;
        if (rd_hazard !== 2'b00) begin n_fail++; $display("FAIL reset_hazard: got %b want 00", rd_hazard); end
        n_checks++;
        if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rd_data); end
        n_checks++;
        if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    endtask

    task automatic test_init_sweep();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            n_checks++;
            if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_low cycle %0d: got %b want 0", k, ready); end
        end
        tick();
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_high: got %b want 1", ready); end
        for (int a = 0; a < 32; a += 2) begin
            rd_en = 2'b11;
            rd_addr = {5'(a + 1), 5'(a)};
            tick();
            n_checks++;
            if (rd_valid !== 2'b11 || rd_data !== 64'h0) begin
                n_fail++;
                $display("FAIL init_zero addr %0d: valid %b data %h want 11/0", a, rd_valid, rd_data);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        tick();
        n_checks++;
        if (rd_valid !== 2'b01) begin n_fail++; $display("FAIL wr_rd_valid: got %b want 01", rd_valid); end
        n_checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data: got %h want deadbeef", rd_data[31:0]); end
        idle();
        tick();
        n_checks++;
        if (rd_valid !== 2'b00 || rd_data[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_hold: valid %b data %h want 00/deadbeef", rd_valid, rd_data[31:0]);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D;
        tick();
        idle();
        rd_en = 2'b11; rd_addr = {5'd3, 5'd9};
        tick();
        n_checks++;
        if (rd_valid !== 2'b11 || rd_data !== 64'hDEADBEEF_0BADF00D) begin
            n_fail++;
            $display("FAIL two_port_read: valid %b data %h want 11/deadbeef0badf00d", rd_valid, rd_data);
        end
        idle();
        tick();
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        n_checks++;
        if (pending !== 32'h0) begin n_fail++; $display("FAIL zero_pending: got %h want 0", pending); end
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        tick();
        n_checks++;
        if (rd_valid !== 2'b11 || rd_data !== 64'h0 || rd_hazard !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_read: valid %b data %h haz %b want 11/0/00", rd_valid, rd_data, rd_hazard);
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        idle();
        n_checks++;
        if (pending !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_set: got %h want 00000080", pending); end
        rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
        tick();
        n_checks++;
        if (rd_valid !== 2'b10 || rd_hazard !== 2'b10) begin
            n_fail++;
            $display("FAIL sb_hazard: valid %b haz %b want 10/10", rd_valid, rd_hazard);
        end
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        tick();
        idle();
        n_checks++;
        if (pending !== 32'h0) begin n_fail++; $display("FAIL sb_clear: got %h want 0", pending); end
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        tick();
        n_checks++;
        if (rd_hazard !== 2'b00 || rd_data[31:0] !== 32'h12) begin
            n_fail++;
            $display("FAIL sb_clean_read: haz %b data %h want 00/12", rd_hazard, rd_data[31:0]);
        end
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h34;
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        idle();
        n_checks++;
        if (pending !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_set_wins: got %h want 00000080", pending); end
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        tick();
        n_checks++;
        if (rd_data[31:0] !== 32'h34 || rd_hazard !== 2'b01) begin
            n_fail++;
            $display("FAIL sb_set_wins_read: data %h haz %b want 34/01", rd_data[31:0], rd_hazard);
        end
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h34;
        tick();
        idle();
        tick();
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
        logic [1:0]  exp_h;
`ifdef REGFILE_BYPASS_EN
        exp_d1 = 32'hA; exp_d2 = 32'hB; exp_h = 2'b00;
`else
        exp_d1 = 32'h1; exp_d2 = 32'hA; exp_h = 2'b01;
`endif
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1;
        tick();
        wr_data = 32'hA;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        tick();
        idle();
        n_checks++;
        if (rd_data[31:0] !== exp_d1) begin n_fail++; $display("FAIL rw_same_data: got %h want %h", rd_data[31:0], exp_d1); end
        rd_en = 2'b01;
        tick();
        n_checks++;
        if (rd_data[31:0] !== 32'hA) begin n_fail++; $display("FAIL rw_after_data: got %h want a", rd_data[31:0]); end
        idle();
        iss_en = 1'b1; iss_addr = 5'd5;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hB;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        tick();
        idle();
        n_checks++;
        if (rd_data[31:0] !== exp_d2 || rd_hazard !== exp_h) begin
            n_fail++;
            $display("FAIL rw_same_hazard: data %h haz %b want %h/%b", rd_data[31:0], rd_hazard, exp_d2, exp_h);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int a = 10; a < 14; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'h100 + 32'(a);
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            rd_en = 2'b11;
            rd_addr = {5'(13 - k), 5'(10 + k)};
            tick();
            n_checks++;
            if (rd_data[31:0] !== 32'h100 + 32'(10 + k) || rd_data[63:32] !== 32'h100 + 32'(13 - k)) begin
                n_fail++;
                $display("FAIL b2b_read step %0d: got %h want %h_%h", k, rd_data,
                         32'h100 + 32'(13 - k), 32'h100 + 32'(10 + k));
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_midrun();
        iss_en = 1'b1; iss_addr = 5'd20;
        tick();
        iss_en = 1'b0;
        rd_en = 2'b11; rd_addr = {5'd3, 5'd9};
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 2'b00 || pending !== 32'h0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: valid %b pending %h ready %b want 00/0/0", rd_valid, pending, ready);
        end
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hFFFF;
        iss_en = 1'b1; iss_addr = 5'd10;
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) tick();
        idle();
        n_checks++;
        if (ready !== 1'b0 || rd_valid !== 2'b00 || pending !== 32'h0) begin
            n_fail++;
            $display("FAIL reinit_ignored: ready %b valid %b pending %h want 0/00/0", ready, rd_valid, pending);
        end
        tick();
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reinit_ready: got %b want 1", ready); end
        rd_en = 2'b11; rd_addr = {5'd3, 5'd9};
        tick();
        n_checks++;
        if (rd_valid !== 2'b11 || rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reinit_cleared: valid %b data %h want 11/0", rd_valid, rd_data);
        end
        rd_addr = {5'd13, 5'd10};
        tick();
        n_checks++;
        if (rd_data !== 64'h0 || rd_hazard !== 2'b00) begin
            n_fail++;
            $display("FAIL reinit_cleared2: data %h haz %b want 0/00", rd_data, rd_hazard);
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_same_cycle_rw();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
